div_iter_unit: RTL

Multi-cycle iterative 32-bit divider for DIV/DIVU in the EX stage. It is the source of the div_stall input consumed by the hazard unit. It raises div_stall while a divide is in flight, then presents {HI,LO} for one or more cycles. It obeys the hazard unit's flush and stall outputs so that an annulled or held instruction is never restarted or lost.

---
 rtl/div_iter_unit_pkg.sv | 34 +++
 rtl/div_iter_unit_if.sv | 26 ++
 rtl/div_restoring_step.sv | 26 ++
 rtl/div_iter_unit.sv | 99 +++++++++
 4 files changed

// File: rtl/div_iter_unit_pkg.sv
// rtl/div_iter_unit_pkg.sv - shared constants, state encoding and sign helpers for the iterative divider
//   Provides: DIV_DATA_W, DIV_ITERS, DIV_IDLE/DIV_BUSY/DIV_DONE state codes,
//   HI/LO slice bounds of the 64-bit result, div_abs and div_negate helpers.
package div_iter_unit_pkg;

    localparam int DIV_DATA_W = 32;
    localparam int DIV_ITERS  = 32;

    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_BUSY = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;

    // result = {HI, LO} = {remainder, quotient}
    localparam int HI_MSB = 63;
    localparam int HI_LSB = 32;
    localparam int LO_MSB = 31;
    localparam int LO_LSB = 0;

    // Magnitude of an operand; the most negative value maps to 0x80000000,
    // which is exactly its magnitude when read as unsigned.
    function automatic logic [31:0] div_abs(input logic [31:0] v, input logic is_signed);
        logic [32:0] ext;
        ext = {is_signed & v[31], v};
        if (ext[32]) begin
            ext = ~ext + 33'd1;
        end
        return ext[31:0];
    endfunction

    function automatic logic [31:0] div_negate(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_iter_unit_if.sv
// rtl/div_iter_unit_if.sv - EX-stage divider handshake bundle
//   master (pipeline/hazard side) drives start, signed_div, a, b, annul, hold;
//   slave (divider) drives div_stall, ready, result.
interface div_iter_unit_if;

    logic        start;
    logic        signed_div;
    logic [31:0] a;
    logic [31:0] b;
    logic        annul;
    logic        hold;
    logic        div_stall;
    logic        ready;
    logic [63:0] result;

    modport master (
        output start, signed_div, a, b, annul, hold,
        input  div_stall, ready, result
    );

    modport slave (
        input  start, signed_div, a, b, annul, hold,
        output div_stall, ready, result
    );

endinterface

// File: rtl/div_restoring_step.sv
// rtl/div_restoring_step.sv - one combinational restoring-division step
//   rem_in: partial remainder, dividend_bit: next dividend bit shifted in,
//   divisor: unsigned divisor; rem_out: next partial remainder, q_bit: quotient bit.
module div_restoring_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem_in,
    input  logic         dividend_bit,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_out,
    output logic         q_bit
);

    logic [W:0]   shifted;
    logic [W-1:0] diff_lo;

    // rem_in < divisor, so the shifted value needs one extra bit and the
    // difference (when taken) always fits back into W bits.
    always_comb begin
        shifted = {rem_in, dividend_bit};
        diff_lo = shifted[W-1:0] - divisor;
        q_bit   = (shifted >= {1'b0, divisor});
        rem_out = q_bit ? diff_lo : shifted[W-1:0];
    end

endmodule

// File: rtl/div_iter_unit.sv
// rtl/div_iter_unit.sv - multi-cycle 32-bit DIV/DIVU unit for the EX stage
//   clk, rst (sync active-high); dif (slave): start, signed_div, a, b, annul, hold in;
//   div_stall, ready, result = {HI remainder, LO quotient} out.
module div_iter_unit
    import div_iter_unit_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W,
    parameter int ITERS  = DIV_ITERS
) (
    input  logic           clk,
    input  logic           rst,
    div_iter_unit_if.slave dif
);

    localparam int CNT_W = $clog2(ITERS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] quo;      // dividend bits shift out the top, quotient bits shift in the bottom
    logic [DATA_W-1:0] dvs;
    logic              q_neg;
    logic              r_neg;
    logic [63:0]       result_q;

    logic [DATA_W-1:0] step_rem;
    logic              step_q;
    logic [DATA_W-1:0] quo_next;
    logic              b_zero;

    div_restoring_step #(.W(DATA_W)) u_step (
        .rem_in       (rem),
        .dividend_bit (quo[DATA_W-1]),
        .divisor      (dvs),
        .rem_out      (step_rem),
        .q_bit        (step_q)
    );

    assign quo_next = {quo[DATA_W-2:0], step_q};
    assign b_zero   = (dif.b == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DIV_IDLE;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            result_q <= '0;
        end else if (dif.annul) begin
            // Kill wins over start and completion; the last result is kept.
            state <= DIV_IDLE;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (dif.start) begin
                        if (b_zero) begin
                            result_q[HI_MSB:HI_LSB] <= dif.a;
                            result_q[LO_MSB:LO_LSB] <= 32'hFFFF_FFFF;
                            state                   <= DIV_DONE;
                        end else begin
                            rem   <= '0;
                            quo   <= div_abs(dif.a, dif.signed_div);
                            dvs   <= div_abs(dif.b, dif.signed_div);
                            q_neg <= dif.signed_div & (dif.a[31] ^ dif.b[31]);
                            r_neg <= dif.signed_div & dif.a[31];
                            cnt   <= '0;
                            state <= DIV_BUSY;
                        end
                    end
                end
                DIV_BUSY: begin
                    rem <= step_rem;
                    quo <= quo_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        result_q[HI_MSB:HI_LSB] <= div_negate(step_rem, r_neg);
                        result_q[LO_MSB:LO_LSB] <= div_negate(quo_next, q_neg);
                        state                   <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    if (!dif.hold) begin
                        state <= DIV_IDLE;
                    end
                end
                default: state <= DIV_IDLE;
            endcase
        end
    end

    assign dif.div_stall = (((state == DIV_IDLE) & dif.start & ~b_zero) | (state == DIV_BUSY)) & ~dif.annul;
    assign dif.ready     = (state == DIV_DONE) & ~dif.annul;
    assign dif.result    = result_q;

endmodule
